// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD width, converter state type and leading-zero helper
package bcd_pkg;
  localparam int BCD_W = 4;
  localparam int MAX_DIGITS = 16;
  typedef enum logic {IDLE, SHIFT} state_t;
  // Digit i is a leading zero when i>0 and it and every digit above it are zero.
  // Callers zero-pad unused upper digits, so a plain shift-and-test suffices.
  function automatic logic lz_digit(input logic [BCD_W*MAX_DIGITS-1:0] d, input int i);
    return (i > 0) && ((d >> (BCD_W * i)) == '0);
  endfunction
endpackage

// File: rtl/bcd_adj3.sv
// bcd_adj3: add 3 to a BCD digit that is 5 or more, ahead of the doubling shift
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter with overflow and leading-zero flags
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      ovf,
  output logic [DIGITS-1:0]         lz_mask
);
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [BIN_W-1:0]          sh;
  logic [BCD_W*DIGITS-1:0]   work;
  logic                      acc;
  logic [BCD_W*DIGITS-1:0]   adj;
  logic [BCD_W*DIGITS-1:0]   next_work;
  logic [BIN_W-1:0]          next_sh;
  logic                      next_acc;
  logic [BCD_W*MAX_DIGITS-1:0] work_ext;
  logic [DIGITS-1:0]         lz_next;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (.d(work[g*BCD_W +: BCD_W]), .q(adj[g*BCD_W +: BCD_W]));
  end
  assign next_work = {adj[BCD_W*DIGITS-2:0], sh[BIN_W-1]};
  assign next_sh   = {sh[BIN_W-2:0], 1'b0};
  assign next_acc  = acc | adj[BCD_W*DIGITS-1];
  // Leading-zero mask of the post-shift digits, used on the final iteration
  always_comb begin
    work_ext = '0;
    work_ext[BCD_W*DIGITS-1:0] = next_work;
    for (int i = 0; i < DIGITS; i++) lz_next[i] = lz_digit(work_ext, i);
  end
  // Control FSM: capture on start, one shift per cycle, publish on the last iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      work    <= '0;
      acc     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      lz_mask <= LZ_RST;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sh    <= bin_in;
          work  <= '0;
          acc   <= 1'b0;
          cnt   <= CNT_W'(BIN_W - 1);
          busy  <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        sh   <= next_sh;
        work <= next_work;
        acc  <= next_acc;
        cnt  <= cnt - CNT_W'(1);
        if (cnt == '0) begin
          bcd_out <= next_work;
          ovf     <= next_acc;
          lz_mask <= lz_next;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      end
    end
  end
endmodule
